// File: rtl/keygen_pkg.sv
// Shared state encoding and width helpers for the RSA private-exponent
// generator and its serial divider.
package keygen_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_REM    = 3'd2;
    localparam logic [2:0] S_SEARCH = 3'd3;
    localparam logic [2:0] S_MUL    = 3'd4;
    localparam logic [2:0] S_DIV    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_rem_div.sv
// Restoring one-bit-per-cycle divider step, MSB first. The next
// quotient/remainder are exposed so the caller can act on the final step.
module serial_rem_div #(
    parameter int NUM_W = 35,
    parameter int DIV_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [NUM_W-1:0] numer,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W:0]   remainder,
    output logic [DIV_W:0]   remainder_next,
    output logic [NUM_W-1:0] quotient_next
);

    logic [NUM_W-1:0] sh;
    logic [NUM_W-1:0] q;
    logic [DIV_W:0]   r;
    logic [DIV_W:0]   trial;
    logic             ge;

    // r < divisor always, so its top bit is zero and drops off the shift
    always_comb begin
        trial          = {r[DIV_W-1:0], sh[NUM_W-1]};
        ge             = trial >= {1'b0, divisor};
        remainder_next = ge ? trial - {1'b0, divisor} : trial;
        quotient_next  = {q[NUM_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0;
            q  <= '0;
            r  <= '0;
        end else if (load) begin
            sh <= numer;
            q  <= '0;
            r  <= '0;
        end else if (step) begin
            sh <= {sh[NUM_W-2:0], 1'b0};
            q  <= quotient_next;
            r  <= remainder_next;
        end
    end

    assign remainder = r;

endmodule

// File: rtl/priv_exp_gen.sv
// RSA private exponent d = e^-1 mod f_n via d = (k*f_n + 1)/e,
// computed with serial remainder, counter search, shift-add and divide.
import keygen_pkg::*;

module priv_exp_gen #(
    parameter int HALF_KEY_LENGTH = 16,
    parameter int e_WIDTH         = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2*HALF_KEY_LENGTH-1:0] f_n,
    input  logic [e_WIDTH-1:0]           e,
    output logic [2*HALF_KEY_LENGTH-1:0] d,
    output logic                         ready,
    output logic                         error
);

    localparam int H2  = 2 * HALF_KEY_LENGTH;
    localparam int N_W = H2 + e_WIDTH;
    localparam int CW  = cnt_width(N_W);

    logic [2:0]         state;
    logic [H2-1:0]      fn_q;
    logic [e_WIDTH-1:0] e_q;
    logic [CW-1:0]      cnt;
    logic [e_WIDTH-1:0] k;
    logic [e_WIDTH:0]   acc;
    logic [N_W-1:0]     prod;

    logic [e_WIDTH:0]   rem;
    logic [e_WIDTH:0]   rem_next;
    logic [N_W-1:0]     quo_next;
    logic [N_W-1:0]     mul_next;
    logic [N_W-1:0]     div_numer;
    logic [e_WIDTH:0]   e_ext;
    logic [e_WIDTH:0]   acc_sum;
    logic [e_WIDTH:0]   acc_next;
    logic               div_load;
    logic               div_step;
    logic               rem_last;
    logic               mul_last;
    logic               div_last;
    logic               e_small;
    logic               hit;

    always_comb begin
        e_ext    = {1'b0, e_q};
        e_small  = e_q[e_WIDTH-1:1] == '0;
        rem_last = cnt == CW'(H2 - 1);
        mul_last = cnt == CW'(e_WIDTH - 1);
        div_last = cnt == CW'(N_W - 1);
        hit      = acc == e_ext - (e_WIDTH+1)'(1);
        acc_sum  = acc + rem;
        acc_next = (acc_sum >= e_ext) ? acc_sum - e_ext : acc_sum;
        // k is consumed MSB first by shifting it left each MUL cycle
        mul_next = {prod[N_W-2:0], 1'b0}
                 + (k[e_WIDTH-1] ? N_W'(fn_q) : '0)
                 + N_W'(mul_last);
        div_load  = (state == S_LOAD) || (state == S_MUL && mul_last);
        div_step  = (state == S_REM) || (state == S_DIV);
        div_numer = (state == S_MUL) ? mul_next
                                     : {fn_q, {e_WIDTH{1'b0}}};
    end

    serial_rem_div #(
        .NUM_W (N_W),
        .DIV_W (e_WIDTH)
    ) u_div (
        .clk            (clk),
        .rst            (rst),
        .load           (div_load),
        .step           (div_step),
        .numer          (div_numer),
        .divisor        (e_q),
        .remainder      (rem),
        .remainder_next (rem_next),
        .quotient_next  (quo_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            fn_q  <= '0;
            e_q   <= '0;
            cnt   <= '0;
            k     <= '0;
            acc   <= '0;
            prod  <= '0;
            d     <= '0;
            ready <= 1'b0;
            error <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        fn_q  <= f_n;
                        e_q   <= e;
                        d     <= '0;
                        ready <= 1'b0;
                        error <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt  <= '0;
                    prod <= '0;
                    if (e_small) begin
                        error <= 1'b1;
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_REM;
                    end
                end
                S_REM: begin
                    if (rem_last) begin
                        cnt <= '0;
                        if (rem_next == '0) begin
                            error <= 1'b1;
                            ready <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            k     <= e_WIDTH'(1);
                            acc   <= rem_next;
                            state <= S_SEARCH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SEARCH: begin
                    if (hit) begin
                        state <= S_MUL;
                    end else if (k == e_q - e_WIDTH'(1)) begin
                        error <= 1'b1;
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        k   <= k + e_WIDTH'(1);
                        acc <= acc_next;
                    end
                end
                S_MUL: begin
                    prod <= mul_next;
                    k    <= {k[e_WIDTH-2:0], 1'b0};
                    if (mul_last) begin
                        cnt   <= '0;
                        state <= S_DIV;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    if (div_last) begin
                        d     <= quo_next[H2-1:0];
                        ready <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // k was chosen so that e divides N exactly, and d < f_n
    a_exact_div: assert property (
        @(posedge clk) disable iff (!rst)
        (state == S_DIV && div_last)
            |-> (rem_next == '0 && quo_next[N_W-1:H2] == '0)
    );

endmodule

// File: tb/tb_priv_exp_gen.sv
// Self-checking bench for priv_exp_gen: directed table, hand sequences
// for restart/abort, and a random prime sweep against a reference model.
module tb_priv_exp_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] f_n;
    logic [2:0]  e;
    logic [31:0] d;
    logic        ready;
    logic        error;

    int errors = 0;
    int checks = 0;

    priv_exp_gen #(
        .HALF_KEY_LENGTH (16),
        .e_WIDTH         (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .f_n   (f_n),
        .e     (e),
        .d     (d),
        .ready (ready),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint unsigned f;
        int              ee;
        longint unsigned exp_d;
        bit              exp_err;
        int              exp_lat;
    } vec_t;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: search k in [1, e-1] with e | (k*f+1) directly
    function automatic void model(input longint unsigned f, input int ee,
                                  output longint unsigned md,
                                  output bit merr, output int mlat);
        md   = 0;
        merr = 1;
        mlat = 0;
        if (ee < 2) begin
            mlat = 1;
        end else if (f % ee == 0) begin
            mlat = 2 * 16 + 1;
        end else begin
            for (int kk = 1; kk < ee; kk++) begin
                if ((kk * f + 1) % ee == 0) begin
                    md   = (kk * f + 1) / ee;
                    merr = 0;
                    mlat = 4 * 16 + 2 * 3 + kk + 1;
                    break;
                end
            end
        end
    endfunction

    function automatic bit is_prime(input int n);
        if (n < 2) return 0;
        for (int i = 2; i * i <= n; i++)
            if (n % i == 0) return 0;
        return 1;
    endfunction

    // Accept a request, optionally pulse a second start at glitch_at,
    // then count cycles until ready rises (bounded).
    task automatic run(input longint unsigned f, input int ee,
                       input int glitch_at,
                       output longint unsigned rd, output bit rerr,
                       output int lat);
        @(posedge clk);
        #1;
        start = 1'b1;
        f_n   = f[31:0];
        e     = ee[2:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        f_n   = $urandom;
        e     = 3'($urandom);
        lat   = 0;
        while (!ready && lat < 300) begin
            if (lat == glitch_at) begin
                start = 1'b1;
                f_n   = 32'd60;
                e     = 3'd7;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        if (!ready) begin
            errors++;
            checks++;
            $display("FAIL timeout: ready never rose for f=%0d e=%0d", f, ee);
        end
        rd   = d;
        rerr = error;
    endtask

    task automatic apply(input string name, input longint unsigned f,
                         input int ee, input int glitch_at);
        longint unsigned md, rd;
        bit              merr, rerr;
        int              mlat, lat;
        model(f, ee, md, merr, mlat);
        run(f, ee, glitch_at, rd, rerr, lat);
        chk({name, " d"}, rd, md);
        chk({name, " error"}, rerr, merr);
        chk({name, " latency"}, lat, mlat);
        if (!merr)
            chk({name, " d*e mod f"}, (rd * ee) % f, 1);
    endtask

    vec_t vt[5];

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        f_n   = '0;
        e     = '0;

        vt[0] = '{40, 3, 27, 0, 73};
        vt[1] = '{60, 7, 43, 0, 76};
        vt[2] = '{64'hFFFF_FFFE, 5, 64'h3333_3333, 0, 72};
        vt[3] = '{60, 3, 0, 1, 33};
        vt[4] = '{60, 1, 0, 1, 1};

        #12;
        chk("reset ready", ready, 0);
        chk("reset error", error, 0);
        chk("reset d", d, 0);
        rst = 1'b1;

        // Table: entries 3 -> 4 restart straight from DONE
        for (int i = 0; i < 5; i++) begin
            longint unsigned rd;
            bit              rerr;
            int              lat;
            run(vt[i].f, vt[i].ee, -1, rd, rerr, lat);
            chk($sformatf("vec%0d d", i), rd, vt[i].exp_d);
            chk($sformatf("vec%0d error", i), rerr, vt[i].exp_err);
            chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
            if (!vt[i].exp_err)
                chk($sformatf("vec%0d inverse", i),
                    (rd * vt[i].ee) % vt[i].f, 1);
        end

        // Restart from DONE: ready/error drop on the accepting edge
        @(posedge clk);
        #1;
        start = 1'b1;
        f_n   = 32'd40;
        e     = 3'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart ready drop", ready, 0);
        chk("restart error drop", error, 0);
        repeat (80) @(posedge clk);
        #1;
        chk("restart result", d, 27);

        // Start pulsed mid-DIV must be ignored
        apply("glitch div", 40, 3, 45);

        // Asynchronous reset from DONE clears outputs without an edge
        chk("pre-reset ready", ready, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async ready", ready, 0);
        chk("async d", d, 0);
        @(negedge clk);
        rst = 1'b1;

        // Abort mid-REM: no result may appear afterwards
        @(posedge clk);
        #1;
        start = 1'b1;
        f_n   = 32'd60;
        e     = 3'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort ready", ready, 0);
        chk("abort error", error, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("abort idle ready", ready, 0);
        apply("after abort", 60, 7, -1);

        // Random prime sweep
        for (int n = 0; n < 200; n++) begin
            int p, q, ee;
            int choice;
            do p = int'($urandom_range(65535, 3)); while (!is_prime(p));
            do q = int'($urandom_range(65535, 3)); while (!is_prime(q));
            choice = int'($urandom_range(2, 0));
            ee = 3 + 2 * choice;
            apply($sformatf("rand%0d", n),
                  longint'(p - 1) * longint'(q - 1), ee, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
